// File: rtl/frame_accum.sv
// rtl/frame_accum.sv - frame accumulator: per-frame sum/max/min/count with held result and drop counter
module frame_accum #(
  parameter int FRAME_LEN = 8
) (
  input  logic        clk_2,
  input  logic        rst,
  input  logic        data_2_valid,
  input  logic [15:0] data_2,
  input  logic        flush,
  input  logic        res_ack,
  output logic        res_valid,
  output logic [19:0] res_sum,
  output logic [15:0] res_max,
  output logic [15:0] res_min,
  output logic [4:0]  res_count,
  output logic [7:0]  drop_cnt,
  output logic        busy
);

  localparam logic [4:0] LEN = 5'(FRAME_LEN);

  typedef enum logic [1:0] {
    IDLE,
    ACC,
    HOLD
  } state_t;

  state_t      state, state_nxt;
  logic [19:0] acc_sum, acc_sum_nxt;
  logic [15:0] acc_max, acc_max_nxt;
  logic [15:0] acc_min, acc_min_nxt;
  logic [4:0]  acc_count, acc_count_nxt;
  logic        load_res;
  logic        drop;

  always_ff @(posedge clk_2 or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Result registers are loaded from the *_nxt values so the final word
  // (including one arriving alongside flush) is visible the cycle after.
  always_comb begin
    state_nxt     = state;
    acc_sum_nxt   = acc_sum;
    acc_max_nxt   = acc_max;
    acc_min_nxt   = acc_min;
    acc_count_nxt = acc_count;
    load_res      = 1'b0;
    drop          = 1'b0;
    case (state)
      IDLE: begin
        if (data_2_valid) begin
          acc_sum_nxt   = {4'd0, data_2};
          acc_max_nxt   = data_2;
          acc_min_nxt   = data_2;
          acc_count_nxt = 5'd1;
          if (LEN == 5'd1) begin
            state_nxt = HOLD;
            load_res  = 1'b1;
          end else begin
            state_nxt = ACC;
          end
        end
      end
      ACC: begin
        if (data_2_valid) begin
          acc_sum_nxt   = acc_sum + {4'd0, data_2};
          acc_max_nxt   = (data_2 > acc_max) ? data_2 : acc_max;
          acc_min_nxt   = (data_2 < acc_min) ? data_2 : acc_min;
          acc_count_nxt = acc_count + 5'd1;
        end
        if (flush || (data_2_valid && (acc_count_nxt == LEN))) begin
          state_nxt = HOLD;
          load_res  = 1'b1;
        end
      end
      HOLD: begin
        drop = data_2_valid;
        if (res_ack) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_2 or negedge rst) begin
    if (!rst) begin
      acc_sum   <= 20'd0;
      acc_max   <= 16'd0;
      acc_min   <= 16'd0;
      acc_count <= 5'd0;
    end else begin
      acc_sum   <= acc_sum_nxt;
      acc_max   <= acc_max_nxt;
      acc_min   <= acc_min_nxt;
      acc_count <= acc_count_nxt;
    end
  end

  always_ff @(posedge clk_2 or negedge rst) begin
    if (!rst) begin
      res_sum   <= 20'd0;
      res_max   <= 16'd0;
      res_min   <= 16'd0;
      res_count <= 5'd0;
    end else if (load_res) begin
      res_sum   <= acc_sum_nxt;
      res_max   <= acc_max_nxt;
      res_min   <= acc_min_nxt;
      res_count <= acc_count_nxt;
    end
  end

  always_ff @(posedge clk_2 or negedge rst) begin
    if (!rst) begin
      drop_cnt <= 8'd0;
    end else if (drop && (drop_cnt != 8'hFF)) begin
      drop_cnt <= drop_cnt + 8'd1;
    end
  end

  assign res_valid = (state == HOLD);
  assign busy      = (state != IDLE);

endmodule

// File: tb/tb_frame_accum.sv
// tb/tb_frame_accum.sv - directed self-checking bench for frame_accum at FRAME_LEN 8, 16 and 1
module tb_frame_accum;

  logic        clk_2 = 1'b0;
  logic        rst;
  logic        data_2_valid;
  logic [15:0] data_2;
  logic        flush;
  logic        res_ack;

  logic        v8, v16, v1;
  logic [19:0] s8, s16, s1;
  logic [15:0] mx8, mx16, mx1;
  logic [15:0] mn8, mn16, mn1;
  logic [4:0]  c8, c16, c1;
  logic [7:0]  d8, d16, d1;
  logic        b8, b16, b1;

  int tests = 0;
  int fails = 0;

  always #5 clk_2 = ~clk_2;

  frame_accum #(.FRAME_LEN(8)) u8 (
    .clk_2(clk_2), .rst(rst), .data_2_valid(data_2_valid), .data_2(data_2),
    .flush(flush), .res_ack(res_ack), .res_valid(v8), .res_sum(s8),
    .res_max(mx8), .res_min(mn8), .res_count(c8), .drop_cnt(d8), .busy(b8)
  );

  frame_accum #(.FRAME_LEN(16)) u16 (
    .clk_2(clk_2), .rst(rst), .data_2_valid(data_2_valid), .data_2(data_2),
    .flush(flush), .res_ack(res_ack), .res_valid(v16), .res_sum(s16),
    .res_max(mx16), .res_min(mn16), .res_count(c16), .drop_cnt(d16), .busy(b16)
  );

  frame_accum #(.FRAME_LEN(1)) u1 (
    .clk_2(clk_2), .rst(rst), .data_2_valid(data_2_valid), .data_2(data_2),
    .flush(flush), .res_ack(res_ack), .res_valid(v1), .res_sum(s1),
    .res_max(mx1), .res_min(mn1), .res_count(c1), .drop_cnt(d1), .busy(b1)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_2);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    #7;
    rst = 1'b1;
    step();
  endtask

  initial begin
    rst = 1'b0; data_2_valid = 1'b0; data_2 = 16'd0; flush = 1'b0; res_ack = 1'b0;
    #12;
    check("rst_valid", v8, 0);
    check("rst_busy", b8, 0);
    check("rst_sum", s8, 0);
    check("rst_count", c8, 0);
    check("rst_drop", d8, 0);
    rst = 1'b1;
    step();

    // words 1..8, with a stray ack during ACC
    for (int i = 1; i <= 8; i++) begin
      data_2_valid = 1'b1; data_2 = 16'(i);
      res_ack = (i == 3);
      step();
      if (i == 7) check("seq_not_yet", v8, 0);
    end
    data_2_valid = 1'b0; res_ack = 1'b0;
    check("seq_valid", v8, 1);
    check("seq_sum", s8, 36);
    check("seq_max", mx8, 8);
    check("seq_min", mn8, 1);
    check("seq_count", c8, 8);
    check("seq_busy", b8, 1);
    step();
    check("seq_hold", v8, 1);
    res_ack = 1'b1; step(); res_ack = 1'b0;
    check("ack_valid", v8, 0);
    check("ack_busy", b8, 0);
    check("ack_sum_kept", s8, 36);

    // partial frame closed by flush with a word on the same edge
    data_2_valid = 1'b1;
    data_2 = 16'hFFFF; step();
    data_2 = 16'h0000; step();
    data_2 = 16'h8000; step();
    data_2 = 16'h0001; flush = 1'b1; step();
    data_2_valid = 1'b0; flush = 1'b0;
    check("flush_valid", v8, 1);
    check("flush_sum", s8, 32'h18000);
    check("flush_max", mx8, 16'hFFFF);
    check("flush_min", mn8, 0);
    check("flush_count", c8, 4);

    // 300 words while held -> saturating drop count, result stable
    for (int i = 0; i < 300; i++) begin
      data_2_valid = 1'b1; data_2 = 16'(i);
      step();
    end
    check("drop_sat", d8, 255);
    check("drop_res_valid", v8, 1);
    check("drop_res_sum", s8, 32'h18000);
    check("drop_res_count", c8, 4);
    data_2 = 16'h0055; res_ack = 1'b1; step();
    res_ack = 1'b0; data_2_valid = 1'b0;
    check("ackdrop_cnt", d8, 255);
    check("ackdrop_valid", v8, 0);
    check("ackdrop_busy", b8, 0);
    step();
    check("ackdrop_idle", b8, 0);
    check("ackdrop_sum", s8, 32'h18000);

    // FRAME_LEN=16 with all-ones words
    do_reset();
    for (int i = 0; i < 16; i++) begin
      data_2_valid = 1'b1; data_2 = 16'hFFFF;
      step();
      if (i == 14) check("f16_not_yet", v16, 0);
    end
    data_2_valid = 1'b0;
    check("f16_valid", v16, 1);
    check("f16_sum", s16, 32'hFFFF0);
    check("f16_max", mx16, 16'hFFFF);
    check("f16_count", c16, 16);
    check("f8_drops", d8, 8);
    res_ack = 1'b1; step(); res_ack = 1'b0;

    // reset in the middle of a frame
    for (int i = 1; i <= 5; i++) begin
      data_2_valid = 1'b1; data_2 = 16'(i);
      step();
    end
    data_2_valid = 1'b0;
    check("mid_busy_pre", b8, 1);
    rst = 1'b0;
    #2;
    check("mid_busy", b8, 0);
    check("mid_valid", v8, 0);
    check("mid_sum", s8, 0);
    check("mid_max", mx8, 0);
    check("mid_drop", d8, 0);
    check("mid_sum16", s16, 0);
    check("mid_count16", c16, 0);
    #4;
    rst = 1'b1;
    step();
    for (int i = 0; i < 8; i++) begin
      data_2_valid = 1'b1; data_2 = 16'(100 + i);
      step();
    end
    data_2_valid = 1'b0;
    check("fresh_valid", v8, 1);
    check("fresh_sum", s8, 828);
    check("fresh_max", mx8, 107);
    check("fresh_min", mn8, 100);
    check("fresh_count", c8, 8);

    // FRAME_LEN=1 and flush while idle
    do_reset();
    flush = 1'b1; step(); flush = 1'b0;
    check("idle_flush_v1", v1, 0);
    check("idle_flush_v8", v8, 0);
    check("idle_flush_b8", b8, 0);
    data_2_valid = 1'b1; data_2 = 16'h1234; step();
    data_2_valid = 1'b0;
    check("f1_valid", v1, 1);
    check("f1_sum", s1, 32'h01234);
    check("f1_max", mx1, 16'h1234);
    check("f1_min", mn1, 16'h1234);
    check("f1_count", c1, 1);
    check("f1_f8_busy", b8, 1);
    check("f1_f8_valid", v8, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/frame_accum.md
FRAME_ACCUM -- requirements
Module: frame_accum

Interface
REQ-001 Parameter: FRAME_LEN, default 8, words per frame; legal range 1..16.
REQ-002 Port: clk_2  input  1  single clock; all state updates on the rising edge.
REQ-003 Port: rst  input  1  reset, asynchronous, active-low (0 = reset asserted).
REQ-004 Port: data_2_valid  input  1  word qualifier from the upstream FIFO read side.
REQ-005 Port: data_2  input  16  unsigned data word, sampled only when data_2_valid=1.
REQ-006 Port: flush  input  1  closes a partial frame.
REQ-007 Port: res_ack  input  1  consumer acknowledge for the held result.
REQ-008 Port: res_valid  output  1  result held and valid.
REQ-009 Port: res_sum  output  20  unsigned sum of the frame's words.
REQ-010 Port: res_max  output  16  largest word in the frame.
REQ-011 Port: res_min  output  16  smallest word in the frame.
REQ-012 Port: res_count  output  5  number of words in the frame (1..16).
REQ-013 Port: drop_cnt  output  8  count of words dropped while a result is held; saturating.
REQ-014 Port: busy  output  1  high in ACC or HOLD.

Function
REQ-015 The block SHALL implement FSM states IDLE, ACC and HOLD; busy SHALL be 1 in ACC and HOLD.
REQ-016 IDLE, data_2_valid=1: load sum=data_2, max=min=data_2, count=1; go to HOLD if FRAME_LEN=1, else go to ACC.
REQ-017 IDLE: flush SHALL be ignored; the block SHALL stay in IDLE with no result produced.
REQ-018 ACC, data_2_valid=1: sum+=data_2 (zero-extended to 20 bits, no overflow possible); max/min updated with unsigned compare; count+=1.
REQ-019 ACC: when the accepted word makes count equal FRAME_LEN, the next state SHALL be HOLD.
REQ-020 ACC, flush=1: the next state SHALL be HOLD with the partial frame; if data_2_valid=1 in the same cycle, that word SHALL be accumulated first.
REQ-021 Output latency: res_valid and all res_* SHALL be valid in the cycle after the edge that accepted the frame's last word, or the edge that sampled flush.
REQ-022 HOLD: res_valid=1 and res_sum, res_max, res_min and res_count SHALL stay stable until res_ack=1 is sampled.
REQ-023 HOLD, res_ack=1: the next state SHALL be IDLE and res_valid SHALL deassert in the following cycle.
REQ-024 res_ack outside HOLD SHALL be ignored.
REQ-025 HOLD, data_2_valid=1: the word SHALL be discarded and drop_cnt incremented, saturating at 255.
REQ-026 HOLD, data_2_valid=1 and res_ack=1 in the same cycle: the word SHALL be dropped; there is no bypass into the next frame.
REQ-027 drop_cnt SHALL clear only on reset.
REQ-028 Words with data_2_valid=0 SHALL never alter state.
REQ-029 Outside HOLD, res_sum, res_max, res_min and res_count SHALL hold their last values; only res_valid qualifies them.

Reset
REQ-030 rst=0 SHALL, asynchronously: state=IDLE; res_valid=0; busy=0; res_sum=0; res_max=0; res_min=0; res_count=0; drop_cnt=0; internal accumulators cleared.
REQ-031 Reset asserted mid-frame or in HOLD SHALL discard the frame with no result emitted.
REQ-032 After rst returns to 1, the first data_2_valid word SHALL start a new frame.

Verification
REQ-033 FRAME_LEN=8, words 1..8 on consecutive cycles -> one cycle after the 8th word: res_valid=1, sum=36, max=8, min=1, count=8; res_ack -> res_valid=0 next cycle.
REQ-034 FRAME_LEN=8, words 0xFFFF,0x0000,0x8000 then flush together with a 4th word 0x0001 -> sum=0x18000, max=0xFFFF, min=0x0000, count=4.
REQ-035 Result held, 300 valid words with no res_ack -> result unchanged, drop_cnt=255; res_ack together with a valid word -> drop_cnt stays 255, state IDLE, no partial frame started.
REQ-036 FRAME_LEN=16, 16 words of 0xFFFF -> sum=0xFFFF0, count=16, no overflow.
REQ-037 Reset pulse after 5 words of a frame -> all outputs 0 immediately; next 8 words form a fresh frame with the correct sum.
REQ-038 FRAME_LEN=1, word 0x1234 -> HOLD directly with sum=0x01234, max=min=0x1234, count=1; flush while IDLE -> no res_valid.
